// File: rtl/imem_access_ctrl.sv
// Single-port instruction memory arbiter: boot-time loader vs. IF-stage fetch.
// Optional macro IMEM_PATCH_EN allows loader writes in RUN while the fetch slot is unused.
module imem_access_ctrl #(
  parameter int                ADDR_W    = 6,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INST  = 32'h00000033,
  parameter bit                BOOT_LOAD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_stall,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_inst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_ovf
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

  // Handshake: a loader word transfers on a rising clk edge where ld_valid && ld_ready.
  typedef enum logic [1:0] {LOAD = 2'd0, DRAIN = 2'd1, RUN = 2'd2} state_t;

  state_t          state;
  logic [ADDR_W:0] word_cnt;
  logic            patch_wr;

  always_comb begin
    ld_ready    = 1'b0;
    mem_addr    = fetch_addr;
    mem_we      = 1'b0;
    mem_wdata   = ld_data;
    fetch_valid = 1'b0;
    fetch_inst  = NOP_INST;
    patch_wr    = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        mem_addr = ld_addr;
        mem_we   = ld_valid;
      end
      RUN: begin
`ifdef IMEM_PATCH_EN
        // The port is free whenever the fetch result would be unused.
        ld_ready = fetch_stall | ~fetch_req;
        patch_wr = ld_valid & ld_ready;
`endif
        if (patch_wr) begin
          mem_addr = ld_addr;
          mem_we   = 1'b1;
        end else begin
          fetch_valid = fetch_req;
          fetch_inst  = mem_rdata;
        end
      end
      default: ;
    endcase
  end

`ifndef IMEM_PATCH_EN
  logic unused_stall;
  assign unused_stall = fetch_stall;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT_LOAD ? LOAD : RUN;
      core_hold <= BOOT_LOAD;
      word_cnt  <= '0;
      load_done <= 1'b0;
      load_ovf  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        LOAD: begin
          if (ld_valid) begin
            word_cnt <= word_cnt + 1'b1;
            if (ld_last) begin
              state     <= DRAIN;
              load_done <= 1'b1;
            end else if (word_cnt == LAST_CNT) begin
              // Depth exhausted without a terminating word.
              state     <= DRAIN;
              load_done <= 1'b1;
              load_ovf  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          word_cnt  <= '0;
          state     <= RUN;
          core_hold <= 1'b0;
        end
        RUN: begin
          if (load_start) begin
            state     <= LOAD;
            core_hold <= 1'b1;
            load_ovf  <= 1'b0;
            word_cnt  <= '0;
          end
        end
        default: begin
          state     <= RUN;
          core_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Bench for imem_access_ctrl: behavioural memory, mode/image reference model, scenario tasks.
module tb_imem_access_ctrl;
  localparam int          ADDR_W = 6;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 64;
  localparam logic [31:0] NOP    = 32'h00000033;
  localparam int M_LOAD = 0, M_DRAIN = 1, M_RUN = 2;

  logic clk = 1'b0;
  logic rst, load_start, ld_valid, ld_ready, ld_last;
  logic fetch_req, fetch_stall, fetch_valid, mem_we;
  logic core_hold, load_done, load_ovf;
  logic [ADDR_W-1:0] ld_addr, fetch_addr, mem_addr;
  logic [DATA_W-1:0] ld_data, fetch_inst, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  imem_access_ctrl dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_hold(core_hold), .load_done(load_done), .load_ovf(load_ovf)
  );

  // Instruction memory: combinational read, synchronous write.
  logic [31:0] mem_arr [DEPTH];
  assign mem_rdata = mem_arr[mem_addr];
  always @(posedge clk) if (mem_we) mem_arr[mem_addr] <= mem_wdata;

  // Reference model: operating mode, words in current burst, overflow flag, expected image.
  int          m_mode, m_cnt;
  logic        m_ovf;
  logic [31:0] img [DEPTH];
  int          n_checks = 0, n_errors = 0;
  logic [37:0] obs_v, exp_v;

  function automatic logic [37:0] observe();
    return {ld_ready, mem_we, fetch_valid, core_hold, load_done, load_ovf, fetch_inst};
  endfunction

  function automatic logic [37:0] predict();
    logic rdy, we, fv, wr;
    logic [31:0] inst;
    rdy = 1'b0; we = 1'b0; fv = 1'b0; inst = NOP;
    if (m_mode == M_LOAD) begin
      rdy = 1'b1;
      we  = ld_valid;
    end else if (m_mode == M_RUN) begin
`ifdef IMEM_PATCH_EN
      rdy = fetch_stall || !fetch_req;
`endif
      wr = ld_valid && rdy;
      if (wr) we = 1'b1;
      else begin
        fv   = fetch_req;
        inst = img[fetch_addr];
      end
    end
    return {rdy, we, fv, (m_mode != M_RUN), (m_mode == M_DRAIN), m_ovf, inst};
  endfunction

  task automatic model_reset();
    m_mode = M_LOAD; m_cnt = 0; m_ovf = 1'b0;
  endtask

  task automatic tick();
    logic [37:0] p;
    logic        acc;
    p   = predict();
    acc = ld_valid && p[37];
    if (!rst) begin
      case (m_mode)
        M_LOAD: if (acc) begin
          img[ld_addr] = ld_data;
          m_cnt++;
          if (ld_last) m_mode = M_DRAIN;
          else if (m_cnt == DEPTH) begin m_ovf = 1'b1; m_mode = M_DRAIN; end
        end
        M_DRAIN: begin m_cnt = 0; m_mode = M_RUN; end
        default: begin
          if (acc) img[ld_addr] = ld_data;
          if (load_start) begin m_mode = M_LOAD; m_cnt = 0; m_ovf = 1'b0; end
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    load_start = 0; ld_valid = 0; ld_addr = '0; ld_data = '0; ld_last = 0;
    fetch_req = 0; fetch_addr = '0; fetch_stall = 0;
  endtask

  task automatic ensure_run();
    int guard = 0;
    drive_idle();
    ld_valid = 1; ld_last = 1; ld_addr = 6'd63; ld_data = $urandom;
    while (m_mode != M_RUN && guard < 20) begin
      #2; exp_v = predict(); obs_v = observe(); n_checks++;
      if (obs_v !== exp_v) begin n_errors++; $display("FAIL settle: got %h want %h", obs_v, exp_v); end
      tick(); guard++;
    end
    n_checks++;
    if (m_mode != M_RUN) begin n_errors++; $display("FAIL settle_timeout: got mode %0d want %0d", m_mode, M_RUN); end
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1;
    model_reset();
    @(posedge clk); #1;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP};
    obs_v = observe(); n_checks++;
    if (obs_v !== exp_v) begin n_errors++; $display("FAIL reset_state: got %h want %h", obs_v, exp_v); end
    rst = 0;
  endtask

  task automatic test_boot_load();
    logic [31:0] boot [3];
    int pulses = 0;
    boot[0] = 32'h00002183; boot[1] = 32'h00402203; boot[2] = 32'h00802283;
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      ld_valid = 1; ld_addr = 6'(i); ld_data = boot[i]; ld_last = (i == 2);
      #2; exp_v = predict(); obs_v = observe(); n_checks++;
      if (obs_v !== exp_v) begin n_errors++; $display("FAIL boot_word%0d: got %h want %h", i, obs_v, exp_v); end
      pulses += int'(load_done);
      tick();
    end
    drive_idle();
    fetch_req = 1; fetch_addr = 6'd1;
    for (int c = 0; c < 3; c++) begin
      #2; exp_v = predict(); obs_v = observe(); n_checks++;
      if (obs_v !== exp_v) begin n_errors++; $display("FAIL boot_post%0d: got %h want %h", c, obs_v, exp_v); end
      if (c == 0) begin
        n_checks++;
        if (!(core_hold && load_done)) begin
          n_errors++; $display("FAIL boot_drain: got hold=%b done=%b want 1 1", core_hold, load_done);
        end
      end
      pulses += int'(load_done);
      tick();
    end
    #2; n_checks++;
    if (fetch_inst !== 32'h00402203 || fetch_valid !== 1'b1 || core_hold !== 1'b0) begin
      n_errors++; $display("FAIL boot_fetch1: got %h v=%b hold=%b want 00402203 v=1 hold=0", fetch_inst, fetch_valid, core_hold);
    end
    n_checks++;
    if (pulses != 1) begin n_errors++; $display("FAIL boot_done_pulses: got %0d want 1", pulses); end
    tick();
  endtask

  task automatic test_overflow_load();
    int accepted = 0, guard = 0;
    drive_idle();
    load_start = 1; fetch_req = 1; fetch_addr = 6'd2;
    #2; exp_v = predict(); obs_v = observe(); n_checks++;
    if (obs_v !== exp_v) begin n_errors++; $display("FAIL ovf_start: got %h want %h", obs_v, exp_v); end
    tick();
    load_start = 0;
    #2; n_checks++;
    if (core_hold !== 1'b1 || fetch_valid !== 1'b0 || fetch_inst !== NOP) begin
      n_errors++; $display("FAIL load_entry: got hold=%b v=%b inst=%h want 1 0 %h", core_hold, fetch_valid, fetch_inst, NOP);
    end
    while (accepted < DEPTH && guard < 400) begin
      ld_valid   = ($urandom_range(0, 3) != 0);
      ld_addr    = 6'(accepted);
      ld_data    = (accepted == 12) ? 32'h00302823 : $urandom;
      ld_last    = 0;
      load_start = ($urandom_range(0, 7) == 0);
      fetch_addr = 6'($urandom_range(0, DEPTH - 1));
      #2; exp_v = predict(); obs_v = observe(); n_checks++;
      if (obs_v !== exp_v) begin n_errors++; $display("FAIL ovf_word%0d: got %h want %h", accepted, obs_v, exp_v); end
      if (ld_valid) accepted++;
      tick(); guard++;
    end
    drive_idle();
    ld_valid = 1; ld_addr = 6'd12; ld_data = 32'hdeadbeef;
    #2; n_checks++;
    if (load_ovf !== 1'b1 || ld_ready !== 1'b0 || mem_we !== 1'b0) begin
      n_errors++; $display("FAIL ovf_drain: got ovf=%b rdy=%b we=%b want 1 0 0", load_ovf, ld_ready, mem_we);
    end
    tick();
    ld_valid = 0;
    #2; n_checks++;
    if (core_hold !== 1'b0 || load_ovf !== 1'b1) begin
      n_errors++; $display("FAIL ovf_run: got hold=%b ovf=%b want 0 1", core_hold, load_ovf);
    end
    tick();
  endtask

  task automatic test_fetch_directed();
    drive_idle();
    fetch_req = 1; fetch_addr = 6'd12;
    #2; n_checks++;
    if (fetch_inst !== 32'h00302823 || mem_we !== 1'b0 || fetch_valid !== 1'b1 || mem_addr !== 6'd12) begin
      n_errors++; $display("FAIL fetch12: got %h we=%b v=%b addr=%0d want 00302823 0 1 12", fetch_inst, mem_we, fetch_valid, mem_addr);
    end
    tick();
  endtask

  task automatic test_random_mix();
    for (int c = 0; c < 250; c++) begin
      load_start  = ($urandom_range(0, 15) == 0);
      ld_valid    = $urandom_range(0, 1);
      ld_addr     = 6'($urandom_range(0, DEPTH - 1));
      ld_data     = $urandom;
      ld_last     = ($urandom_range(0, 3) == 0);
      fetch_req   = $urandom_range(0, 1);
      fetch_addr  = 6'($urandom_range(0, DEPTH - 1));
      fetch_stall = $urandom_range(0, 1);
      #2; exp_v = predict(); obs_v = observe(); n_checks++;
      if (obs_v !== exp_v) begin n_errors++; $display("FAIL random_c%0d: got %h want %h", c, obs_v, exp_v); end
      tick();
    end
    ensure_run();
  endtask

  task automatic test_patch();
    logic [31:0] d;
    d = $urandom;
    drive_idle();
    fetch_req = 1; fetch_addr = 6'd5; ld_valid = 1; ld_addr = 6'd5; ld_data = d; ld_last = 1;
    #2; n_checks++;
    if (ld_ready !== 1'b0 || mem_we !== 1'b0 || fetch_valid !== 1'b1 || fetch_inst !== img[5]) begin
      n_errors++; $display("FAIL patch_unstalled: got rdy=%b we=%b v=%b inst=%h want 0 0 1 %h", ld_ready, mem_we, fetch_valid, fetch_inst, img[5]);
    end
    tick();
    fetch_stall = 1;
    #2;
`ifdef IMEM_PATCH_EN
    n_checks++;
    if (ld_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd5 || fetch_valid !== 1'b0 || fetch_inst !== NOP) begin
      n_errors++; $display("FAIL patch_stalled: got rdy=%b we=%b addr=%0d v=%b inst=%h want 1 1 5 0 %h", ld_ready, mem_we, mem_addr, fetch_valid, fetch_inst, NOP);
    end
`else
    n_checks++;
    if (ld_ready !== 1'b0 || mem_we !== 1'b0 || fetch_valid !== 1'b1) begin
      n_errors++; $display("FAIL readonly_stalled: got rdy=%b we=%b v=%b want 0 0 1", ld_ready, mem_we, fetch_valid);
    end
`endif
    tick();
    drive_idle();
    fetch_req = 1; fetch_addr = 6'd5;
    #2; n_checks++;
    if (load_done !== 1'b0 || core_hold !== 1'b0) begin
      n_errors++; $display("FAIL patch_no_done: got done=%b hold=%b want 0 0", load_done, core_hold);
    end
    n_checks++;
`ifdef IMEM_PATCH_EN
    if (fetch_inst !== d || fetch_valid !== 1'b1) begin
      n_errors++; $display("FAIL patch_readback: got %h v=%b want %h v=1", fetch_inst, fetch_valid, d);
    end
`else
    if (fetch_inst !== img[5] || fetch_valid !== 1'b1) begin
      n_errors++; $display("FAIL readonly_readback: got %h v=%b want %h v=1", fetch_inst, fetch_valid, img[5]);
    end
`endif
    tick();
  endtask

  task automatic test_reset_mid_load();
    int accepted = 0, guard = 0;
    drive_idle();
    load_start = 1;
    tick();
    for (int i = 0; i < 10; i++) begin
      drive_idle();
      ld_valid = 1; ld_addr = 6'($urandom_range(0, DEPTH - 1)); ld_data = $urandom;
      #2; exp_v = predict(); obs_v = observe(); n_checks++;
      if (obs_v !== exp_v) begin n_errors++; $display("FAIL midload_word%0d: got %h want %h", i, obs_v, exp_v); end
      tick();
    end
    drive_idle();
    rst = 1;
    #1; model_reset(); n_checks++;
    if (core_hold !== 1'b1 || ld_ready !== 1'b1 || load_done !== 1'b0 || load_ovf !== 1'b0 || fetch_valid !== 1'b0) begin
      n_errors++; $display("FAIL midload_reset: got hold=%b rdy=%b done=%b ovf=%b v=%b want 1 1 0 0 0", core_hold, ld_ready, load_done, load_ovf, fetch_valid);
    end
    tick();
    rst = 0;
    while (accepted < DEPTH && guard < 400) begin
      ld_valid = $urandom_range(0, 1);
      ld_addr  = 6'($urandom_range(0, DEPTH - 1));
      ld_data  = $urandom;
      #2; exp_v = predict(); obs_v = observe(); n_checks++;
      if (obs_v !== exp_v) begin n_errors++; $display("FAIL reload_word%0d: got %h want %h", accepted, obs_v, exp_v); end
      if (ld_valid) accepted++;
      tick(); guard++;
    end
    drive_idle();
    #2; n_checks++;
    if (load_ovf !== 1'b1 || load_done !== 1'b1) begin
      n_errors++; $display("FAIL reload_ovf: got ovf=%b done=%b want 1 1", load_ovf, load_done);
    end
    tick();
    ensure_run();
  endtask

  initial begin
    rst = 1;
    drive_idle();
    test_reset();
    test_boot_load();
    test_overflow_load();
    test_fetch_directed();
    test_random_mix();
    test_patch();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
